// File: rtl/axis_uart_pkg.sv
// Shared types and line-level constants for the AXI-Stream UART transmitter.
// Optional feature macro: AXIS_UART_TX_PARITY_EN (even parity bit per word).
package axis_uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

  // Counter width for a range 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: clk_cnt walks 0..CLOCKS_PER_PULSE-1 while enabled and
// tick marks the last cycle of each bit. clr restarts the period on a new beat.
module uart_baud_tick
  import axis_uart_pkg::*;
#(
  parameter int CLOCKS_PER_PULSE = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CW = cnt_w(CLOCKS_PER_PULSE);

  logic [CW-1:0] clk_cnt;

  assign tick = en && (clk_cnt == CW'(CLOCKS_PER_PULSE - 1));

  // Free-running bit period counter, wraps on tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       clk_cnt <= '0;
    else if (clr)  clk_cnt <= '0;
    else if (tick) clk_cnt <= '0;
    else if (en)   clk_cnt <= clk_cnt + 1'b1;
  end

endmodule

// File: rtl/axis_uart_tx.sv
// AXI-Stream to UART transmitter. A W_IN-bit beat is split into
// BITS_PER_WORD-bit words, sent word 0 first, each framed as
// start(0), data LSB first, [even parity], stop(1).
// Optional feature macro: AXIS_UART_TX_PARITY_EN.
module axis_uart_tx
  import axis_uart_pkg::*;
#(
  parameter int CLOCKS_PER_PULSE = 4,
  parameter int W_IN             = 16,
  parameter int BITS_PER_WORD    = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic [W_IN-1:0] s_data,
  output logic            tx,
  output logic            busy
);

  localparam int NUM_WORDS = W_IN / BITS_PER_WORD;
  localparam int BW        = cnt_w(BITS_PER_WORD);
  localparam int WW        = cnt_w(NUM_WORDS);

  if ((W_IN % BITS_PER_WORD) != 0) begin : g_bad_width
    $error("axis_uart_tx: W_IN must be a multiple of BITS_PER_WORD");
  end
  if (CLOCKS_PER_PULSE < 1) begin : g_bad_cpp
    $error("axis_uart_tx: CLOCKS_PER_PULSE must be >= 1");
  end

  tx_state_e        state;
  logic [W_IN-1:0]  shreg;
  logic [BW-1:0]    bit_cnt;
  logic [WW-1:0]    word_cnt;
  logic             tick;
  logic             hs;
`ifdef AXIS_UART_TX_PARITY_EN
  logic             par;
`endif

  assign hs = s_valid && s_ready;

  uart_baud_tick #(
    .CLOCKS_PER_PULSE(CLOCKS_PER_PULSE)
  ) u_baud (
    .clk (clk),
    .rst (rst),
    .clr (hs),
    .en  (busy),
    .tick(tick)
  );

  // Frame sequencer. The shift register always holds the next data bit at
  // bit 0, so after BITS_PER_WORD shifts the next word is already in place.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      tx       <= IDLE_LEVEL;
      s_ready  <= 1'b0;
      busy     <= 1'b0;
      shreg    <= '0;
      bit_cnt  <= '0;
      word_cnt <= '0;
`ifdef AXIS_UART_TX_PARITY_EN
      par      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          tx <= IDLE_LEVEL;
          if (!s_ready) begin
            s_ready <= 1'b1;
          end else if (s_valid) begin
            shreg    <= s_data;
            s_ready  <= 1'b0;
            busy     <= 1'b1;
            tx       <= START_BIT;
            bit_cnt  <= '0;
            word_cnt <= '0;
            state    <= START;
          end
        end
        START: begin
          if (tick) begin
            tx      <= shreg[0];
            shreg   <= shreg >> 1;
            bit_cnt <= '0;
`ifdef AXIS_UART_TX_PARITY_EN
            par     <= shreg[0];
`endif
            state   <= DATA;
          end
        end
        DATA: begin
          if (tick) begin
            if (bit_cnt == BW'(BITS_PER_WORD - 1)) begin
`ifdef AXIS_UART_TX_PARITY_EN
              tx    <= par;
              state <= PARITY;
`else
              tx    <= STOP_BIT;
              state <= STOP;
`endif
            end else begin
              tx      <= shreg[0];
              shreg   <= shreg >> 1;
              bit_cnt <= bit_cnt + 1'b1;
`ifdef AXIS_UART_TX_PARITY_EN
              par     <= par ^ shreg[0];
`endif
            end
          end
        end
`ifdef AXIS_UART_TX_PARITY_EN
        PARITY: begin
          if (tick) begin
            tx    <= STOP_BIT;
            state <= STOP;
          end
        end
`endif
        STOP: begin
          if (tick) begin
            if (word_cnt == WW'(NUM_WORDS - 1)) begin
              tx      <= IDLE_LEVEL;
              s_ready <= 1'b1;
              busy    <= 1'b0;
              state   <= IDLE;
            end else begin
              word_cnt <= word_cnt + 1'b1;
              tx       <= START_BIT;
              state    <= START;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_uart_tx.sv
// Directed bench for axis_uart_tx (default parameters). Checks every line
// cycle of each beat against the expected frame, decodes mid-bit samples
// back into the beat, and covers reset, back-to-back and mid-frame reset.
// Honours AXIS_UART_TX_PARITY_EN when defined for the build.
module tb_axis_uart_tx;

  localparam int CPP = 4;
  localparam int BPW = 8;
  localparam int NW  = 2;
`ifdef AXIS_UART_TX_PARITY_EN
  localparam int FB  = BPW + 3;
`else
  localparam int FB  = BPW + 2;
`endif
  localparam int BEAT = NW * FB * CPP;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_valid = 1'b0;
  logic [15:0] s_data = '0;
  logic        s_ready, tx, busy;

  int errors = 0;
  int checks = 0;

  logic        lvl [0:BEAT-1];
  logic [15:0] rx_word;
  logic [15:0] rnd;

  always #5 clk = ~clk;

  axis_uart_tx #(
    .CLOCKS_PER_PULSE(CPP),
    .W_IN(16),
    .BITS_PER_WORD(BPW)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .s_data (s_data),
    .tx     (tx),
    .busy   (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected line level for frame-bit index b of beat d.
  function automatic logic exp_bit(input logic [15:0] d, input int b);
    int w, j;
    w = b / FB;
    j = b % FB;
    if (j == 0) return 1'b0;
    if (j <= BPW) return d[w*BPW + j - 1];
`ifdef AXIS_UART_TX_PARITY_EN
    if (j == BPW + 1) return ^d[w*BPW +: BPW];
`endif
    return 1'b1;
  endfunction

  // Present d, wait (bounded) for s_ready, return just after the handshake edge.
  task automatic handshake(input logic [15:0] d);
    int n;
    n = 0;
    s_data  = d;
    s_valid = 1'b1;
    @(negedge clk);
    while (!s_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("hs_ready_timeout", {31'b0, s_ready}, 32'd1);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  // Check every cycle of a beat starting right after its handshake edge.
  task automatic check_beat(input logic [15:0] d, input string tag);
    int b, j, w;
    rx_word = 'x;
    for (int c = 0; c < BEAT; c++) begin
      @(negedge clk);
      b = c / CPP;
      lvl[c] = tx;
      chk($sformatf("%s_tx_c%0d", tag, c), {31'b0, tx}, {31'b0, exp_bit(d, b)});
      if (c == 0 || c == BEAT - 1) begin
        chk($sformatf("%s_busy_c%0d", tag, c), {31'b0, busy}, 32'd1);
        chk($sformatf("%s_rdy_c%0d", tag, c), {31'b0, s_ready}, 32'd0);
      end
      if (c % CPP == CPP / 2) begin
        j = b % FB;
        w = b / FB;
        if (j >= 1 && j <= BPW) rx_word[w*BPW + j - 1] = tx;
      end
    end
    @(negedge clk);
    chk({tag, "_end_rdy"},  {31'b0, s_ready}, 32'd1);
    chk({tag, "_end_busy"}, {31'b0, busy},    32'd0);
    chk({tag, "_end_tx"},   {31'b0, tx},      32'd1);
  endtask

  initial begin
    // Reset held for 3 cycles
    repeat (3) @(negedge clk);
    chk("rst_tx",    {31'b0, tx},      32'd1);
    chk("rst_ready", {31'b0, s_ready}, 32'd0);
    chk("rst_busy",  {31'b0, busy},    32'd0);
    rst = 1'b0;
    #1;
    chk("rel_ready_before_edge", {31'b0, s_ready}, 32'd0);
    @(negedge clk);
    chk("rel_ready_after_edge", {31'b0, s_ready}, 32'd1);
    chk("idle_tx", {31'b0, tx}, 32'd1);
    repeat (3) @(negedge clk);
    chk("idle_no_valid_tx", {31'b0, tx}, 32'd1);

    // Single beat: 0,0,0,1,1,1,1,0,0,1 then 0,1,0,1,0,0,1,0,1,1
    handshake(16'hA53C);
    check_beat(16'hA53C, "a53c");
    chk("a53c_rx", {16'b0, rx_word}, 32'h0000A53C);

    // Back-to-back: valid held high, data changes after the first handshake
    handshake(16'h00FF);
    s_valid = 1'b1;
    s_data  = 16'h8001;
    check_beat(16'h00FF, "b2b0");
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    check_beat(16'h8001, "b2b1");
    chk("b2b1_rx", {16'b0, rx_word}, 32'h00008001);

    // Reset in the middle of a beat
    handshake(16'h0000);
    repeat (20) @(negedge clk);
    chk("mid_tx_low", {31'b0, tx}, 32'd0);
    #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_tx",    {31'b0, tx},      32'd1);
    chk("mid_rst_busy",  {31'b0, busy},    32'd0);
    chk("mid_rst_ready", {31'b0, s_ready}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_rel_ready", {31'b0, s_ready}, 32'd0);
    handshake(16'h1234);
    check_beat(16'h1234, "after_rst");
    chk("after_rst_rx", {16'b0, rx_word}, 32'h00001234);

    // Parity content beat: byte 0x3C (even ones) then 0x01 (odd ones)
    handshake(16'h013C);
    check_beat(16'h013C, "par");
`ifdef AXIS_UART_TX_PARITY_EN
    chk("par_bit_3c", {31'b0, lvl[(BPW+1)*CPP + 1]},      32'd0);
    chk("par_bit_01", {31'b0, lvl[(FB+BPW+1)*CPP + 1]},   32'd1);
`endif

    // Loopback: random beats with random idle gaps, decoded from the line
    for (int i = 0; i < 10; i++) begin
      rnd = 16'($urandom);
      repeat ($urandom_range(1, 100)) @(negedge clk);
      handshake(rnd);
      check_beat(rnd, $sformatf("lb%0d", i));
      chk($sformatf("lb%0d_rx", i), {16'b0, rx_word}, {16'b0, rnd});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
